// File: rtl/step_decrement_counter.sv
// -----------------------------------------------------------------------------
// step_decrement_counter
//   Registered WIDTH-bit up/down counter. Each enabled cycle it moves by a
//   programmable step. It can be loaded in parallel, can wrap or saturate at
//   the limits, and reports terminal count, underflow and overflow.
//
// Parameters
//   WIDTH   counter width in bits (>= 2)
//   STEP_W  width of step_i (1..WIDTH); the step is zero-extended
//
// Ports
//   clk_i       rising-edge clock
//   rst_n_i     synchronous active-low reset
//   load_i      load load_val_i into the counter (takes priority over en_i)
//   load_val_i  parallel load value
//   en_i        apply one step this cycle
//   dir_i       0 = decrement, 1 = increment
//   step_i      unsigned step magnitude
//   sat_i       1 = saturate at 0 / all-ones, 0 = wrap
//   count_o     registered counter value
//   zero_o      count_o == 0 (decoded from the count register)
//   tc_o        one-cycle pulse: a non-zero decrement landed exactly on 0
//   uflow_o     a decrement crossed below 0
//   oflow_o     an increment crossed above all-ones
//
// Configuration
//   DECCNT_STICKY_FLAGS_EN  when defined, uflow_o and oflow_o stay set until
//                           the next load or reset. Otherwise they are
//                           one-cycle pulses.
// -----------------------------------------------------------------------------
module step_decrement_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  load_val_i,
    input  logic              en_i,
    input  logic              dir_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              sat_i,
    output logic [WIDTH-1:0]  count_o,
    output logic              zero_o,
    output logic              tc_o,
    output logic              uflow_o,
    output logic              oflow_o
);

`ifdef DECCNT_STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             uflow_q, uflow_d;
    logic             oflow_q, oflow_d;

    // The arithmetic uses one extra bit. Bit WIDTH of the difference is the
    // borrow, and bit WIDTH of the sum is the carry.
    logic [WIDTH:0] step_ext;
    logic [WIDTH:0] diff;
    logic [WIDTH:0] sum;
    logic           borrow;
    logic           carry;
    logic           step_nz;
    logic           uflow_hold;
    logic           oflow_hold;

    assign step_ext = {{(WIDTH + 1 - STEP_W){1'b0}}, step_i};
    assign diff     = {1'b0, count_q} - step_ext;
    assign sum      = {1'b0, count_q} + step_ext;
    assign borrow   = diff[WIDTH];
    assign carry    = sum[WIDTH];
    assign step_nz  = |step_i;

    // The value a flag keeps when nothing sets it: 0 in pulse mode, and the
    // current value in sticky mode.
    assign uflow_hold = STICKY & uflow_q;
    assign oflow_hold = STICKY & oflow_q;

    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        uflow_d = uflow_hold;
        oflow_d = oflow_hold;

        if (load_i) begin
            count_d = load_val_i;
            uflow_d = 1'b0;
            oflow_d = 1'b0;
        end else if (en_i) begin
            if (!dir_i) begin
                uflow_d = uflow_hold | borrow;
                if (borrow) begin
                    count_d = sat_i ? '0 : diff[WIDTH-1:0];
                end else begin
                    count_d = diff[WIDTH-1:0];
                    // A zero step leaves the counter where it is. It must not
                    // retrigger tc while the counter is parked at 0.
                    tc_d    = (diff[WIDTH-1:0] == '0) & step_nz;
                end
            end else begin
                oflow_d = oflow_hold | carry;
                if (carry) begin
                    count_d = sat_i ? MAX_VAL : sum[WIDTH-1:0];
                end else begin
                    count_d = sum[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            uflow_q <= 1'b0;
            oflow_q <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            uflow_q <= uflow_d;
            oflow_q <= oflow_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);
    assign tc_o    = tc_q;
    assign uflow_o = uflow_q;
    assign oflow_o = oflow_q;

endmodule

// File: tb/tb_step_decrement_counter.sv
// -----------------------------------------------------------------------------
// tb_step_decrement_counter
//   Testbench for step_decrement_counter with WIDTH=8 and STEP_W=4. It runs
//   directed scenarios and then random cycles. Every output is compared each
//   cycle against an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_step_decrement_counter;

    localparam int W   = 8;
    localparam int SW  = 4;
    localparam int MAX = (1 << W) - 1;

`ifdef DECCNT_STICKY_FLAGS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [W-1:0]  load_val;
    logic          en;
    logic          dir;
    logic [SW-1:0] step;
    logic          sat;
    logic [W-1:0]  count;
    logic          zero;
    logic          tc;
    logic          uflow;
    logic          oflow;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int m_count = 0;
    bit m_tc = 0, m_uf = 0, m_of = 0;

    always #5 clk = ~clk;

    step_decrement_counter #(.WIDTH(W), .STEP_W(SW)) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .load_i    (load),
        .load_val_i(load_val),
        .en_i      (en),
        .dir_i     (dir),
        .step_i    (step),
        .sat_i     (sat),
        .count_o   (count),
        .zero_o    (zero),
        .tc_o      (tc),
        .uflow_o   (uflow),
        .oflow_o   (oflow)
    );

    // The model works on plain integers: a decrement result below 0 or an
    // increment result above MAX is the out-of-range case.
    task automatic model_edge(input bit r, input bit l, input int lv, input bit e,
                              input bit d, input int s, input bit sa);
        int res;
        bit uf_new, of_new;
        if (!r) begin
            m_count = 0; m_tc = 0; m_uf = 0; m_of = 0;
        end else if (l) begin
            m_count = lv; m_tc = 0; m_uf = 0; m_of = 0;
        end else begin
            uf_new = 0; of_new = 0; m_tc = 0;
            if (e && !d) begin
                res = m_count - s;
                if (res < 0) begin
                    uf_new  = 1;
                    m_count = sa ? 0 : res + MAX + 1;
                end else begin
                    m_count = res;
                    m_tc    = (res == 0) && (s != 0);
                end
            end else if (e && d) begin
                res = m_count + s;
                if (res > MAX) begin
                    of_new  = 1;
                    m_count = sa ? MAX : res - (MAX + 1);
                end else begin
                    m_count = res;
                end
            end
            m_uf = (STICKY && m_uf) || uf_new;
            m_of = (STICKY && m_of) || of_new;
        end
    endtask

    task automatic check_all(input string tag);
        logic [W-1:0] exp_cnt;
        exp_cnt = W'(m_count);
        tests++;
        assert (count === exp_cnt) else begin
            fails++; $error("FAIL %s count: got %0d expected %0d", tag, count, exp_cnt);
        end
        tests++;
        assert (zero === (m_count == 0)) else begin
            fails++; $error("FAIL %s zero: got %b expected %b", tag, zero, (m_count == 0));
        end
        tests++;
        assert (tc === m_tc) else begin
            fails++; $error("FAIL %s tc: got %b expected %b", tag, tc, m_tc);
        end
        tests++;
        assert (uflow === m_uf) else begin
            fails++; $error("FAIL %s uflow: got %b expected %b", tag, uflow, m_uf);
        end
        tests++;
        assert (oflow === m_of) else begin
            fails++; $error("FAIL %s oflow: got %b expected %b", tag, oflow, m_of);
        end
    endtask

    // A fixed expectation taken directly from the scenario description,
    // independent of the model.
    task automatic check_val(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++; $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive the inputs, let the edge happen, advance the model,
    // then sample #1 after the edge.
    task automatic cyc(input string tag, input bit r, input bit l, input int lv,
                       input bit e, input bit d, input int s, input bit sa);
        rst_n    = r;
        load     = l;
        load_val = W'(lv);
        en       = e;
        dir      = d;
        step     = SW'(s);
        sat      = sa;
        @(posedge clk);
        model_edge(r, l, lv, e, d, s, sa);
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 0; load = 0; load_val = '0; en = 0; dir = 0; step = '0; sat = 0;
        @(posedge clk); #1;

        // Reset beats load
        cyc("reset_vs_load", 0, 1, 'h55, 1, 0, 0, 0);
        check_val("reset_count", int'(count), 0);
        check_val("reset_zero", int'(zero), 1);

        // Countdown with wrap
        cyc("cd_load", 1, 1, 10, 0, 0, 0, 0);
        cyc("cd_5", 1, 0, 0, 1, 0, 5, 0);
        check_val("cd_5_count", int'(count), 5);
        cyc("cd_0", 1, 0, 0, 1, 0, 5, 0);
        check_val("cd_0_tc", int'(tc), 1);
        check_val("cd_0_zero", int'(zero), 1);
        cyc("cd_wrap", 1, 0, 0, 1, 0, 5, 0);
        check_val("cd_wrap_count", int'(count), 251);
        check_val("cd_wrap_uflow", int'(uflow), 1);
        check_val("cd_wrap_tc", int'(tc), 0);

        // Saturating decrement, then parked at 0
        cyc("sat_load", 1, 1, 3, 0, 0, 0, 0);
        cyc("sat_dn", 1, 0, 0, 1, 0, 7, 1);
        check_val("sat_dn_count", int'(count), 0);
        cyc("sat_park1", 1, 0, 0, 1, 0, 7, 1);
        cyc("sat_park2", 1, 0, 0, 1, 0, 7, 1);
        check_val("sat_park_tc", int'(tc), 0);
        check_val("sat_park_uflow", int'(uflow), 1);

        // Saturating increment
        cyc("satup_load", 1, 1, 250, 0, 0, 0, 0);
        cyc("satup", 1, 0, 0, 1, 1, 9, 1);
        check_val("satup_count", int'(count), 255);
        check_val("satup_oflow", int'(oflow), 1);

        // Wrapping increment, then an idle cycle (pulse or sticky)
        cyc("wrap_load", 1, 1, 250, 0, 0, 0, 0);
        cyc("wrap_up", 1, 0, 0, 1, 1, 9, 0);
        check_val("wrap_up_count", int'(count), 3);
        cyc("wrap_idle", 1, 0, 0, 0, 0, 0, 0);
        cyc("wrap_dn", 1, 0, 0, 1, 0, 1, 0);
        cyc("wrap_reload", 1, 1, 100, 0, 0, 0, 0);
        check_val("reload_oflow", int'(oflow), 0);

        // Load beats en, and a mid-sequence reset beats en
        cyc("prio_load", 1, 1, 7, 1, 1, 9, 0);
        check_val("prio_load_count", int'(count), 7);
        cyc("prio_rst", 0, 0, 0, 1, 1, 3, 0);
        check_val("prio_rst_count", int'(count), 0);

        // A zero step holds the count in both directions
        cyc("s0_load", 1, 1, 4, 0, 0, 0, 0);
        cyc("s0_dn", 1, 0, 0, 1, 0, 0, 0);
        cyc("s0_up", 1, 0, 0, 1, 1, 0, 1);
        check_val("s0_count", int'(count), 4);

        // Zero step at 0 must not raise tc
        cyc("s0z_load", 1, 1, 0, 0, 0, 0, 0);
        cyc("s0z_dn", 1, 0, 0, 1, 0, 0, 0);

        // Random cycles
        for (int i = 0; i < 600; i++) begin
            bit r, l, e, d, sa;
            int lv, s;
            r  = ($urandom_range(0, 40) != 0);
            l  = ($urandom_range(0, 9) == 0);
            e  = ($urandom_range(0, 3) != 0);
            d  = $urandom_range(0, 1);
            sa = $urandom_range(0, 1);
            s  = $urandom_range(0, 15);
            case ($urandom_range(0, 3))
                0: lv = $urandom_range(0, 15);
                1: lv = $urandom_range(240, 255);
                default: lv = $urandom_range(0, 255);
            endcase
            cyc("rand", r, l, lv, e, d, s, sa);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
